// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC waveform sequencer.
package dac_seq_pkg;

    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_MANUAL = 2'd3
    } mode_e;

    // ST_STEP exists as a named phase but is folded into the HOLD exit edge,
    // so the register never actually holds it.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_HOLD   = 2'd2,
        ST_STEP   = 2'd3
    } state_e;

endpackage

// File: rtl/dac_seq_next.sv
// Next-code unit: steps the current code toward the active endpoint,
// clamps at the endpoint and flags when the endpoint is already reached.
module dac_seq_next #(
    parameter int NB = 8
) (
    input  logic [NB-1:0] cur,
    input  logic [NB-1:0] step,
    input  logic [NB-1:0] start,
    input  logic [NB-1:0] stop,
    input  logic          dir,      // 1 = counting up
    output logic [NB-1:0] nxt,
    output logic          at_end,
    output logic          dir_next
);
    logic [NB-1:0] lo;
    logic [NB-1:0] hi;
    logic [NB:0]   sum;
    logic [NB:0]   diff;

    // One extra bit on sum/diff exposes overflow and underflow before clamping.
    always_comb begin
        lo       = (start <= stop) ? start : stop;
        hi       = (start <= stop) ? stop  : start;
        at_end   = (cur == (dir ? hi : lo));
        dir_next = at_end ? ~dir : dir;
        sum      = {1'b0, cur} + {1'b0, step};
        diff     = {1'b0, cur} - {1'b0, step};
        if (dir_next) begin
            nxt = (sum > {1'b0, hi}) ? hi : sum[NB-1:0];
        end else begin
            nxt = (diff[NB] || (diff[NB-1:0] < lo)) ? lo : diff[NB-1:0];
        end
    end

endmodule

// File: rtl/dac_seq.sv
// DAC waveform sequencer: single ramp, sawtooth, triangle and manual
// pass-through, with a programmable dwell per code.
module dac_seq
    import dac_seq_pkg::*;
#(
    parameter int N  = 256,
    parameter int NB = $clog2(N),
    parameter int DW = DEF_DW
) (
    input  logic          r_Clk,
    input  logic          r_Rst_L,
    input  logic          i_go,
    input  logic          i_abort,
    input  logic [1:0]    i_mode,
    input  logic [NB-1:0] i_start_code,
    input  logic [NB-1:0] i_stop_code,
    input  logic [NB-1:0] i_step,
    input  logic [DW-1:0] i_dwell,
    input  logic [NB-1:0] i_manual_code,
    output logic [NB-1:0] o_dac_code,
    output logic          o_busy,
    output logic          o_update,
    output logic          o_done
);
    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [NB-1:0] start_q, start_d;
    logic [NB-1:0] stop_q, stop_d;
    logic [NB-1:0] step_q, step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [NB-1:0] code_q, code_d;
    logic          upd_q, upd_d;
    logic          done_q, done_d;

    logic [NB-1:0] nxt;
    logic          at_end;
    logic          dir_next;

    dac_seq_next #(.NB(NB)) u_next (
        .cur      (code_q),
        .step     (step_q),
        .start    (start_q),
        .stop     (stop_q),
        .dir      (dir_q),
        .nxt      (nxt),
        .at_end   (at_end),
        .dir_next (dir_next)
    );

    // Next-state, config capture, dwell timer and code selection.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_go && !i_abort) begin
                    mode_d  = mode_e'(i_mode);
                    start_d = i_start_code;
                    stop_d  = i_stop_code;
                    step_d  = (i_step == '0) ? NB'(1) : i_step;
                    dwell_d = i_dwell;
                    if (i_mode == MODE_MANUAL) begin
                        state_d = ST_MANUAL;
                        code_d  = i_manual_code;
                    end else begin
                        state_d = ST_HOLD;
                        code_d  = i_start_code;
                        cnt_d   = i_dwell;
                        dir_d   = (i_start_code <= i_stop_code);
                    end
                end
            end
            ST_MANUAL: begin
                if (i_abort) state_d = ST_IDLE;
                else         code_d  = i_manual_code;
            end
            default: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_q - DW'(1);
                end else if (at_end && mode_q == MODE_SINGLE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    // Dwell expired: advance and reload in the same cycle so
                    // every code is visible for exactly dwell+1 cycles.
                    state_d = ST_HOLD;
                    cnt_d   = dwell_q;
                    if (at_end && mode_q == MODE_SAW) begin
                        code_d = start_q;
                    end else begin
                        code_d = nxt;
                        if (mode_q == MODE_TRI) dir_d = dir_next;
                    end
                end
            end
        endcase
        upd_d = (code_d != code_q);
    end

    // State, shadow config and output registers.
    always_ff @(posedge r_Clk or negedge r_Rst_L) begin
        if (!r_Rst_L) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SINGLE;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            code_q  <= '0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
        end
    end

    assign o_dac_code = code_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_update   = upd_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_dac_seq.sv
// Scoreboard bench for dac_seq: drivers push predicted update/done events,
// a negedge monitor pops and compares them as the DUT pulses.
module tb_dac_seq;
    localparam int NB = 8;
    localparam int DW = 16;

    logic          r_Clk = 1'b0;
    logic          r_Rst_L = 1'b1;
    logic          i_go = 1'b0;
    logic          i_abort = 1'b0;
    logic [1:0]    i_mode = '0;
    logic [NB-1:0] i_start_code = '0;
    logic [NB-1:0] i_stop_code = '0;
    logic [NB-1:0] i_step = '0;
    logic [DW-1:0] i_dwell = '0;
    logic [NB-1:0] i_manual_code = '0;
    logic [NB-1:0] o_dac_code;
    logic          o_busy, o_update, o_done;

    dac_seq #(.N(256)) dut (
        .r_Clk(r_Clk), .r_Rst_L(r_Rst_L), .i_go(i_go), .i_abort(i_abort),
        .i_mode(i_mode), .i_start_code(i_start_code), .i_stop_code(i_stop_code),
        .i_step(i_step), .i_dwell(i_dwell), .i_manual_code(i_manual_code),
        .o_dac_code(o_dac_code), .o_busy(o_busy), .o_update(o_update), .o_done(o_done)
    );

    always #5 r_Clk = ~r_Clk;

    int cyc = 0;
    always @(posedge r_Clk) cyc <= cyc + 1;

    typedef struct { int t; bit dn; int code; } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;
    int  nvec = 0, nerr = 0;
    int  mcode = 0;   // code the model says is currently on the output
    int  seq[$];      // model's list of codes, one per dwell period

    task automatic check(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every update/done pulse must match the next predicted event.
    always @(negedge r_Clk) begin
        if (r_Rst_L && (o_update || o_done)) begin
            if (exp_q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_event: upd=%0b done=%0b code=%0d at cycle %0d, expected none",
                         o_update, o_done, o_dac_code, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_time", cyc, mon_e.t);
                check("event_is_done", int'(o_done), int'(mon_e.dn));
                check("event_code", int'(o_dac_code), mon_e.code);
            end
        end
    end

    // Reference: list the codes a sweep visits, one entry per dwell period.
    task automatic build(input int mode, input int s, input int e, input int st, input int nseg);
        int cur, lo, hi;
        bit up;
        seq.delete();
        if (st == 0) st = 1;
        lo = (s < e) ? s : e;
        hi = (s < e) ? e : s;
        up = (s <= e);
        cur = s;
        seq.push_back(cur);
        while (seq.size() < nseg) begin
            if (mode == 0 && cur == e) break;
            if (mode == 1 && cur == e) begin
                cur = s;
            end else begin
                if (mode == 2 && cur == (up ? hi : lo)) up = !up;
                if (up) cur = (cur + st > hi) ? hi : cur + st;
                else    cur = (cur - st < lo) ? lo : cur - st;
            end
            seq.push_back(cur);
        end
    endtask

    // Predict update events for codes first shown at or before tmax.
    task automatic push_seq(input int g, input int per, input int tmax);
        int t;
        for (int i = 0; i < seq.size(); i++) begin
            t = g + 1 + i * per;
            if (t > tmax) break;
            if (seq[i] != mcode) exp_q.push_back('{t, 1'b0, seq[i]});
            mcode = seq[i];
        end
    endtask

    task automatic drive_go(input int mode, input int s, input int e, input int st, input int d);
        i_mode = 2'(mode); i_start_code = NB'(s); i_stop_code = NB'(e);
        i_step = NB'(st); i_dwell = DW'(d); i_go = 1'b1;
    endtask

    task automatic run_sweep(input int mode, input int s, input int e, input int st,
                             input int d, input int len, input bit mid_go);
        int g, per, tdone, busy_n;
        per = d + 1;
        tdone = 0;
        @(negedge r_Clk);
        drive_go(mode, s, e, st, d);
        g = cyc;
        build(mode, s, e, st, (mode == 0) ? 100000 : len / per + 2);
        push_seq(g, per, (mode == 0) ? 32'h7fffffff : g + len);
        if (mode == 0) begin
            tdone = g + 1 + seq.size() * per;
            exp_q.push_back('{tdone, 1'b1, e});
        end
        @(negedge r_Clk);
        i_go = 1'b0;
        check("busy_on_load", int'(o_busy), 1);
        check("first_code", int'(o_dac_code), s);
        // Later input changes must not disturb the captured config.
        i_start_code = NB'($urandom); i_stop_code = NB'($urandom); i_step = NB'($urandom);
        i_dwell = DW'($urandom_range(0, 3)); i_mode = 2'($urandom_range(0, 2));
        if (mode == 0) begin
            busy_n = 0;
            while (cyc <= tdone) begin
                if (o_busy) busy_n++;
                @(negedge r_Clk);
            end
            check("busy_cycles", busy_n, tdone - g - 1);
            check("busy_after_done", int'(o_busy), 0);
            check("code_after_done", int'(o_dac_code), e);
        end else begin
            while (cyc < g + len) begin
                i_go = (mid_go && cyc == g + len / 2);
                @(negedge r_Clk);
            end
            i_go = 1'b0; i_abort = 1'b1;
            @(negedge r_Clk);
            i_abort = 1'b0;
            check("abort_busy", int'(o_busy), 0);
            check("abort_code", int'(o_dac_code), mcode);
            repeat (3) @(negedge r_Clk);
            check("frozen_code", int'(o_dac_code), mcode);
        end
        repeat (2) @(negedge r_Clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_manual(input int vals[$]);
        int g;
        @(negedge r_Clk);
        i_mode = 2'd3; i_manual_code = NB'(vals[0]); i_go = 1'b1;
        g = cyc;
        for (int k = 0; k < vals.size(); k++) begin
            if (vals[k] != mcode) exp_q.push_back('{g + 1 + k, 1'b0, vals[k]});
            mcode = vals[k];
        end
        for (int k = 1; k < vals.size(); k++) begin
            @(negedge r_Clk);
            i_manual_code = NB'(vals[k]); i_mode = 2'd0; i_go = (k == 2);
            if (k == 1) check("manual_busy", int'(o_busy), 1);
        end
        @(negedge r_Clk);
        i_go = 1'b0; i_abort = 1'b1; i_manual_code = NB'(mcode ^ 8'hff);
        @(negedge r_Clk);
        i_abort = 1'b0;
        check("manual_abort_busy", int'(o_busy), 0);
        check("manual_abort_code", int'(o_dac_code), mcode);
        repeat (2) @(negedge r_Clk);
        check("manual_queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int g;
        int mv[$];
        #1 r_Rst_L = 1'b0;
        repeat (2) @(negedge r_Clk);
        check("rst_code", int'(o_dac_code), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_update", int'(o_update), 0);
        check("rst_done", int'(o_done), 0);
        r_Rst_L = 1'b1;

        // Reset mid-sweep: single ramp 0->10 step 3 dwell 2.
        @(negedge r_Clk);
        drive_go(0, 0, 10, 3, 2);
        g = cyc;
        build(0, 0, 10, 3, 1000);
        push_seq(g, 3, g + 7);
        @(negedge r_Clk);
        i_go = 1'b0;
        repeat (6) @(negedge r_Clk);
        #2 r_Rst_L = 1'b0;
        #1;
        check("midrst_code", int'(o_dac_code), 0);
        check("midrst_busy", int'(o_busy), 0);
        check("midrst_update", int'(o_update), 0);
        check("midrst_done", int'(o_done), 0);
        check("midrst_events_seen", exp_q.size(), 0);
        exp_q.delete();
        mcode = 0;
        @(negedge r_Clk);
        @(negedge r_Clk);
        r_Rst_L = 1'b1;

        run_sweep(0, 0, 10, 3, 2, 0, 1'b0);      // single up, clamp at 10
        run_sweep(0, 5, 2, 0, 0, 0, 1'b0);       // single down, step 0 -> 1
        run_sweep(2, 250, 255, 4, 0, 23, 1'b0);  // triangle near top, no wrap
        mv = '{7, 7, 20, 20, 3};
        run_manual(mv);

        // go + abort together from IDLE: stays idle, code untouched.
        @(negedge r_Clk);
        drive_go(0, mcode ^ 8'h55, 0, 1, 0);
        i_abort = 1'b1;
        @(negedge r_Clk);
        i_go = 1'b0; i_abort = 1'b0;
        check("goabort_busy", int'(o_busy), 0);
        check("goabort_code", int'(o_dac_code), mcode);
        repeat (3) @(negedge r_Clk);
        check("goabort_code_later", int'(o_dac_code), mcode);

        run_sweep(1, 20, 3, 5, 1, 40, 1'b1);     // sawtooth down, go mid-run ignored
        run_sweep(0, 9, 9, 2, 1, 0, 1'b0);       // single, start == stop
        run_sweep(1, 33, 33, 0, 0, 15, 1'b0);    // loop, start == stop
        run_sweep(2, 40, 10, 7, 1, 50, 1'b1);    // triangle starting downward

        for (int r = 0; r < 8; r++) begin
            run_sweep($urandom_range(0, 2), $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 40), $urandom_range(0, 3), $urandom_range(20, 80), r[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
